// File: rtl/iserdes_prbs_checker_pkg.sv
// Shared definitions for the SERDES loopback receive checker: FSM states and
// standard PRBS tap masks over the history vector h[W-1:0].
package iserdes_prbs_checker_pkg;

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [6:0]  PRBS7_TAPS  = 7'b1100000;          // x^7  + x^6  + 1
    localparam logic [14:0] PRBS15_TAPS = 15'b110000000000000; // x^15 + x^14 + 1
    localparam logic [30:0] PRBS31_TAPS = 31'h4800_0000;       // x^31 + x^28 + 1

    // Default tap mask for a given history length; unknown lengths fall back to PRBS7.
    function automatic logic [30:0] prbs_taps(input int width);
        case (width)
            15:      prbs_taps = 31'(PRBS15_TAPS);
            31:      prbs_taps = PRBS31_TAPS;
            default: prbs_taps = 31'(PRBS7_TAPS);
        endcase
    endfunction

endpackage

// File: rtl/iserdes_prbs_checker_sipo_word.sv
// Serial-to-parallel word assembler: MSB-first shift register with a free-running
// bit counter; presents each completed word with a one-cycle strobe.
module iserdes_prbs_checker_sipo_word #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ce,
    input  logic                  din,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  stb
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] BIT_LAST = CW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] shift_next;
    logic [CW-1:0]         bit_cnt;

    assign shift_next = {shift[DATA_WIDTH-2:0], din};

    // NOTE: the shift register is reset like any other flop; it is small and a
    // defined value keeps the first assembled word deterministic.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            shift   <= '0;
            bit_cnt <= '0;
            word    <= '0;
            stb     <= 1'b0;
        end else begin
            stb <= 1'b0;
            if (ce) begin
                shift <= shift_next;
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt <= '0;
                    word    <= shift_next;
                    stb     <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/iserdes_prbs_checker.sv
// Receive side of the SERDES loopback test: word assembly plus a self-synchronising
// PRBS checker with lock detection, stretched error flag and saturating error count.
module iserdes_prbs_checker
    import iserdes_prbs_checker_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    LFSR_WIDTH    = 7,
    parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS     = LFSR_WIDTH'(prbs_taps(LFSR_WIDTH)),
    parameter int                    LOCK_COUNT    = 64,
    parameter int                    UNLOCK_ERRORS = 4,
    parameter int                    ERROR_HOLD    = 4,
    parameter int                    CNT_WIDTH     = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  I_CE,
    input  logic                  I_DAT,
    input  logic                  I_CLR_CNT,
    output logic [DATA_WIDTH-1:0] O_DAT,
    output logic                  O_STB,
    output logic                  O_LOCKED,
    output logic                  O_ERROR,
    output logic [CNT_WIDTH-1:0]  O_ERR_CNT
);

    localparam int SW = (LFSR_WIDTH    > 1) ? $clog2(LFSR_WIDTH)    : 1;
    localparam int GW = (LOCK_COUNT    > 1) ? $clog2(LOCK_COUNT)    : 1;
    localparam int WW = $clog2(LOCK_COUNT + 1);
    localparam int EW = (UNLOCK_ERRORS > 1) ? $clog2(UNLOCK_ERRORS) : 1;
    localparam int HW = (ERROR_HOLD    > 0) ? $clog2(ERROR_HOLD + 1) : 1;

    localparam logic [SW-1:0] SEED_LAST   = SW'(LFSR_WIDTH - 1);
    localparam logic [GW-1:0] GOOD_LAST   = GW'(LOCK_COUNT - 1);
    localparam logic [WW-1:0] WIN_FULL    = WW'(LOCK_COUNT);
    localparam logic [EW-1:0] UNLOCK_LAST = EW'(UNLOCK_ERRORS - 1);
    localparam logic [HW-1:0] HOLD_LOAD   = HW'(ERROR_HOLD);

    state_t                state, state_n;
    logic [LFSR_WIDTH-1:0] hist;
    logic [SW-1:0]         seed_cnt, seed_n;
    logic [GW-1:0]         good_cnt, good_n;
    logic [WW-1:0]         win_cnt, win_n;
    logic [EW-1:0]         win_err, win_err_n, win_base;
    logic [HW-1:0]         hold_cnt;
    logic [CNT_WIDTH-1:0]  err_cnt;
    logic                  pred, mismatch, new_win, hit;

    iserdes_prbs_checker_sipo_word #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sipo (
        .CLK  (CLK),
        .RST  (RST),
        .ce   (I_CE),
        .din  (I_DAT),
        .word (O_DAT),
        .stb  (O_STB)
    );

    assign pred     = ^(hist & LFSR_TAPS);
    assign mismatch = (I_DAT != pred) || (hist == '0);

    // NOTE: every variable gets a default before the case so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_n   = state;
        seed_n    = seed_cnt;
        good_n    = good_cnt;
        win_n     = win_cnt;
        win_err_n = win_err;
        new_win   = (win_cnt == WIN_FULL);
        win_base  = new_win ? '0 : win_err;
        hit       = 1'b0;
        if (I_CE) begin
            case (state)
                ST_SEED: begin
                    if (seed_cnt == SEED_LAST) begin
                        seed_n  = '0;
                        good_n  = '0;
                        state_n = ST_CHECK;
                    end else begin
                        seed_n = seed_cnt + SW'(1);
                    end
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        good_n = '0;
                    end else if (good_cnt == GOOD_LAST) begin
                        good_n    = '0;
                        win_n     = '0;
                        win_err_n = '0;
                        state_n   = ST_LOCKED;
                    end else begin
                        good_n = good_cnt + GW'(1);
                    end
                end
                ST_LOCKED: begin
                    // win_cnt holds bits already in the window; a full window means
                    // this bit opens the next one, so its error lands there.
                    win_n     = new_win ? WW'(1) : win_cnt + WW'(1);
                    win_err_n = win_base;
                    if (mismatch) begin
                        hit = 1'b1;
                        if (win_base == UNLOCK_LAST) begin
                            win_err_n = '0;
                            seed_n    = '0;
                            state_n   = ST_SEED;
                        end else begin
                            win_err_n = win_base + EW'(1);
                        end
                    end
                end
                default: state_n = ST_SEED;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= ST_SEED;
            hist     <= '0;
            seed_cnt <= '0;
            good_cnt <= '0;
            win_cnt  <= '0;
            win_err  <= '0;
            hold_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            state    <= state_n;
            seed_cnt <= seed_n;
            good_cnt <= good_n;
            win_cnt  <= win_n;
            win_err  <= win_err_n;
            if (I_CE) begin
                hist <= {hist[LFSR_WIDTH-2:0], I_DAT};
            end
            if (hit) begin
                hold_cnt <= HOLD_LOAD;
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HW'(1);
            end
            if (I_CLR_CNT) begin
                err_cnt <= '0;
            end else if (hit && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign O_LOCKED  = (state == ST_LOCKED);
    assign O_ERROR   = (hold_cnt != '0);
    assign O_ERR_CNT = err_cnt;

endmodule
